lab3_bit_serializer: RTL and testbench



---
 rtl/lab3_bit_serializer.sv | 108 ++++++++++
 tb/tb_lab3_bit_serializer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lab3_bit_serializer.sv
// MSB-first bit serializer with length clamp, enable stalls and a one-cycle done pulse.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after the pattern bits.
module lab3_bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic [3:0]       len,
    input  logic             en,
    output logic             x,
    output logic             busy,
    output logic             done
);

    localparam int FW = WIDTH + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_n;
    logic [FW-1:0]    frame, frame_n;
    logic [3:0]       rem, rem_n;
    logic             x_n, busy_n, done_n;

    logic [3:0]       eff;
    logic [WIDTH-1:0] masked;
    logic [WIDTH-1:0] first;
    logic [FW-1:0]    shifted;
    logic             accept;

    always_comb begin
        eff = (len > 4'(WIDTH)) ? 4'(WIDTH) : len;
        masked = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < int'(eff)) masked[i] = data_in[i];
        end
        first   = masked >> (eff - 4'd1);
        // rem counts bits still to come after the one now on x
        shifted = frame >> (rem - 4'd1);
        accept  = load && (len != 4'd0) && (state != SHIFT);

        state_n = state;
        frame_n = frame;
        rem_n   = rem;
        x_n     = x;
        busy_n  = busy;
        done_n  = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (accept) begin
`ifdef SERIALIZER_PARITY_EN
                    frame_n = {masked, ^masked};
                    rem_n   = eff;
`else
                    frame_n = {1'b0, masked};
                    rem_n   = eff - 4'd1;
`endif
                    x_n     = first[0];
                    busy_n  = 1'b1;
                    state_n = SHIFT;
                end else begin
                    x_n     = 1'b0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (rem == 4'd0) begin
                        x_n     = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        rem_n = rem - 4'd1;
                        x_n   = shifted[0];
                    end
                end
            end
            default: begin
                x_n     = 1'b0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            frame <= '0;
            rem   <= '0;
            x     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            frame <= frame_n;
            rem   <= rem_n;
            x     <= x_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_lab3_bit_serializer.sv
// Testbench for lab3_bit_serializer: directed table, corner sequences and
// random traffic against a queue-based frame model.
module tb_lab3_bit_serializer;

    logic       clock;
    logic       reset;
    logic       load;
    logic [7:0] data_in;
    logic [3:0] len;
    logic       en;
    logic       x;
    logic       busy;
    logic       done;

    int vectors;
    int miscompares;
    int cyc;

    lab3_bit_serializer #(.WIDTH(8)) dut (
        .clock(clock),
        .reset(reset),
        .load(load),
        .data_in(data_in),
        .len(len),
        .en(en),
        .x(x),
        .busy(busy),
        .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       ld;
        logic [7:0] d;
        logic [3:0] l;
        logic       e;
        logic [2:0] exp;
    } vec_t;

    vec_t tbl[$];

    bit q[$];
    bit m_done;

    task automatic add(input logic ld, input logic [7:0] d,
                       input logic [3:0] l, input logic e,
                       input logic [2:0] exp);
        vec_t v;
        v.ld = ld; v.d = d; v.l = l; v.e = e; v.exp = exp;
        tbl.push_back(v);
    endtask

    function automatic void model_update(input logic rs, input logic ld,
                                         input logic [7:0] d,
                                         input logic [3:0] l, input logic e);
        int n;
        bit p;
        if (!rs) begin
            q.delete();
            m_done = 0;
            return;
        end
        if (q.size() > 0) begin
            m_done = 0;
            if (e) begin
                void'(q.pop_front());
                if (q.size() == 0) m_done = 1;
            end
        end else begin
            m_done = 0;
            if (ld && l != 0) begin
                n = (l > 8) ? 8 : int'(l);
                p = 0;
                for (int i = n - 1; i >= 0; i--) begin
                    q.push_back(d[i]);
                    p = p ^ d[i];
                end
`ifdef SERIALIZER_PARITY_EN
                q.push_back(p);
`endif
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [2:0] got,
                       input logic [2:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d x/busy/done got %b want %b",
                     nm, cyc, got, exp);
        end
    endtask

    task automatic step(input logic rs, input logic ld,
                        input logic [7:0] d, input logic [3:0] l,
                        input logic e);
        logic [2:0] exp;
        reset = rs; load = ld; data_in = d; len = l; en = e;
        @(posedge clock);
        model_update(rs, ld, d, l, e);
        #1;
        cyc++;
        exp = {(q.size() > 0) ? q[0] : 1'b0, q.size() > 0, m_done};
        chk("model", {x, busy, done}, exp);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        m_done = 0;
        reset = 1'b0; load = 1'b0; data_in = '0; len = '0; en = 1'b0;

        // plain 0x69 frame, then 0xA5 short and clamped
        add(1, 8'h69, 8, 1, 3'b010);
        add(0, 8'h00, 0, 1, 3'b110);
        add(0, 8'h00, 0, 1, 3'b110);
        add(0, 8'h00, 0, 1, 3'b010);
        add(0, 8'h00, 0, 1, 3'b110);
        add(0, 8'h00, 0, 1, 3'b010);
        add(0, 8'h00, 0, 1, 3'b010);
        add(0, 8'h00, 0, 1, 3'b110);
        add(0, 8'h00, 0, 1, 3'b001);
        add(0, 8'h00, 0, 1, 3'b000);
        add(1, 8'hA5, 3, 1, 3'b110);
        add(0, 8'h00, 0, 1, 3'b010);
        add(0, 8'h00, 0, 1, 3'b110);
        add(0, 8'h00, 0, 1, 3'b001);
        add(0, 8'h00, 0, 1, 3'b000);
        add(1, 8'hA5, 12, 1, 3'b110);
        add(0, 8'h00, 0, 1, 3'b010);
        add(0, 8'h00, 0, 1, 3'b110);
        add(0, 8'h00, 0, 1, 3'b010);
        add(0, 8'h00, 0, 1, 3'b010);
        add(0, 8'h00, 0, 1, 3'b110);
        add(0, 8'h00, 0, 1, 3'b010);
        add(0, 8'h00, 0, 1, 3'b110);
        add(0, 8'h00, 0, 1, 3'b001);
        add(1, 8'hFF, 0, 1, 3'b000);

        step(0, 1, 8'hFF, 8, 1);
        chk("reset_state", {x, busy, done}, 3'b000);
        step(0, 0, 8'h00, 0, 0);
        chk("reset_hold", {x, busy, done}, 3'b000);

        foreach (tbl[i]) begin
            step(1, tbl[i].ld, tbl[i].d, tbl[i].l, tbl[i].e);
`ifndef SERIALIZER_PARITY_EN
            chk($sformatf("table%0d", i), {x, busy, done}, tbl[i].exp);
`endif
        end

        // stall during cycles 3-4, ignored load in cycle 5
        step(1, 1, 8'hF0, 8, 1);
        for (int c = 1; c <= 10; c++) begin
            step(1, c == 5, 8'h0F, 8, !(c == 3 || c == 4));
`ifndef SERIALIZER_PARITY_EN
            if (c == 10) chk("stall_done", {x, busy, done}, 3'b001);
`endif
        end
        step(1, 0, 8'h00, 0, 1);
`ifndef SERIALIZER_PARITY_EN
        chk("stall_noframe", {x, busy, done}, 3'b000);
`endif
        for (int c = 0; c < 4; c++) step(1, 0, 8'h00, 0, 1);

        // back-to-back with load held high
        for (int c = 0; c <= 9; c++) begin
            step(1, 1, (c <= 8) ? 8'hC3 : 8'h3C, 8, 1);
`ifndef SERIALIZER_PARITY_EN
            if (c == 8) chk("b2b_done", {x, busy, done}, 3'b001);
            if (c == 9) chk("b2b_first", {x, busy, done}, 3'b010);
`endif
        end
        for (int c = 0; c < 12; c++) step(1, 0, 8'h00, 0, 1);

        // reset in the middle of a frame
        step(1, 1, 8'hFF, 8, 1);
        for (int c = 1; c <= 4; c++) step(c != 4, 0, 8'h00, 0, 1);
        chk("rst_clear", {x, busy, done}, 3'b000);
        for (int c = 0; c < 10; c++) begin
            step(1, 0, 8'h00, 0, 1);
            chk("rst_nodone", {x, busy, done}, 3'b000);
        end

`ifdef SERIALIZER_PARITY_EN
        step(1, 1, 8'h69, 8, 1);
        for (int c = 1; c <= 9; c++) begin
            step(1, 0, 8'h00, 0, 1);
            if (c == 8) chk("par_bit0", {x, busy, done}, 3'b010);
            if (c == 9) chk("par_done", {x, busy, done}, 3'b001);
        end
        step(1, 1, 8'h07, 8, 1);
        for (int c = 1; c <= 9; c++) begin
            step(1, 0, 8'h00, 0, 1);
            if (c == 8) chk("par_bit1", {x, busy, done}, 3'b110);
        end
`endif

        for (int c = 0; c < 500; c++) begin
            step($urandom_range(0, 39) != 0,
                 $urandom_range(0, 3) == 0,
                 8'($urandom),
                 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
